// File: rtl/seq_alu_if.sv
// seq_alu_if: request/response bundle between a requester and the
// sequential ALU.
//
// Ports / members:
//   in_valid, op, a, b  - request (driven by master)
//   in_ready            - ALU can accept a request (driven by slave)
//   out_valid, result,
//   carryout, zero,
//   negative, overflow  - response (driven by slave)
//   out_ready           - consumer takes the result (driven by master)
//
// Modports: master is the requester/consumer side, slave is the ALU side.
interface seq_alu_if #(
  parameter int WIDTH = 64
);

  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carryout;
  logic             zero;
  logic             negative;
  logic             overflow;

  // The requester drives the operands and accepts results.
  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, carryout, zero, negative, overflow
  );

  // The ALU consumes operands and presents results.
  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, carryout, zero, negative, overflow
  );

endinterface

// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ALU with a valid/ready request and response.
//
// Ports:
//   clk    - single clock, all state changes on the rising edge
//   reset  - asynchronous, active-high; aborts any operation in flight
//   bus    - seq_alu_if.slave (request, result and flags)
//
// Operations (op): 000 AND, 001 XOR, 010 ADD, 011 SUB, 100 OR,
// 101 SLT (signed), 110 SLL, 111 SRL. Shifts use b[SHW-1:0] as the amount
// and take one cycle per bit; everything else takes a single cycle.
// WIDTH is expected to be a power of two, at least 8.
module seq_alu #(
  parameter int WIDTH = 64
) (
  input logic     clk,
  input logic     reset,
  seq_alu_if.slave bus
);

  localparam int SHW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    SHIFT,
    HOLD
  } state_t;

  state_t           state_q;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] work_q;
  logic [SHW-1:0]   shiftCnt_q;
  logic [WIDTH-1:0] result_q;
  logic             carry_q;
  logic             zero_q;
  logic             negative_q;
  logic             overflow_q;
  logic             outValid_q;
  logic             inReady_q;

  logic             isSub;
  logic [WIDTH-1:0] bOperand;
  logic [WIDTH:0]   sum;
  logic             addOverflow;
  logic [WIDTH-1:0] aluResult_d;
  logic             aluCarry_d;
  logic             aluOverflow_d;
  logic [WIDTH-1:0] shiftWork_d;
  logic [SHW-1:0]   reqShamt;
  logic             reqIsShift;

  // Request decode straight off the bus: a shift with a non-zero amount
  // goes down the bit-serial path, a zero-amount shift is just a copy of a
  // and goes through the ordinary single-cycle path.
  assign reqShamt   = bus.b[SHW-1:0];
  assign reqIsShift = (bus.op[2:1] == 2'b11);

  // Single-cycle ALU working on the captured operands. SUB and SLT share
  // one adder fed with the inverted b and a carry-in of one, so SLT's
  // sign decision is the true signed comparison even when a-b overflows.
  // Zero-amount shifts are the only shifts that reach EXEC, so they simply
  // return a.
  always_comb begin
    isSub         = (op_q == 3'b011) || (op_q == 3'b101);
    bOperand      = isSub ? ~b_q : b_q;
    sum           = {1'b0, a_q} + {1'b0, bOperand} + {{WIDTH{1'b0}}, isSub};
    addOverflow   = (a_q[WIDTH-1] == bOperand[WIDTH-1]) &&
                    (sum[WIDTH-1] != a_q[WIDTH-1]);
    aluResult_d   = '0;
    aluCarry_d    = 1'b0;
    aluOverflow_d = 1'b0;
    case (op_q)
      3'b000: aluResult_d = a_q & b_q;
      3'b001: aluResult_d = a_q ^ b_q;
      3'b010, 3'b011: begin
        aluResult_d   = sum[WIDTH-1:0];
        aluCarry_d    = sum[WIDTH];
        aluOverflow_d = addOverflow;
      end
      3'b100: aluResult_d = a_q | b_q;
      3'b101: aluResult_d = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ addOverflow};
      default: aluResult_d = a_q;
    endcase
  end

  // One-bit step of the serial shifter; op bit 0 picks right (SRL) over
  // left (SLL), and both fill with zeros.
  always_comb begin
    shiftWork_d = op_q[0] ? (work_q >> 1) : (work_q << 1);
  end

  // Control FSM plus all registered outputs. in_ready is a register that
  // is set whenever the machine sits in IDLE, so it comes up on the first
  // edge after reset and drops on the accept edge. Results and flags are
  // only written when entering HOLD, so they keep their previous values
  // while a new operation runs and stay frozen while the consumer stalls.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      work_q     <= '0;
      shiftCnt_q <= '0;
      result_q   <= '0;
      carry_q    <= 1'b0;
      zero_q     <= 1'b0;
      negative_q <= 1'b0;
      overflow_q <= 1'b0;
      outValid_q <= 1'b0;
      inReady_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          inReady_q <= 1'b1;
          if (inReady_q && bus.in_valid) begin
            inReady_q <= 1'b0;
            op_q      <= bus.op;
            a_q       <= bus.a;
            b_q       <= bus.b;
            if (reqIsShift && (reqShamt != '0)) begin
              work_q     <= bus.a;
              shiftCnt_q <= reqShamt;
              state_q    <= SHIFT;
            end else begin
              state_q <= EXEC;
            end
          end
        end
        EXEC: begin
          result_q   <= aluResult_d;
          carry_q    <= aluCarry_d;
          overflow_q <= aluOverflow_d;
          zero_q     <= (aluResult_d == '0);
          negative_q <= aluResult_d[WIDTH-1];
          outValid_q <= 1'b1;
          state_q    <= HOLD;
        end
        SHIFT: begin
          work_q     <= shiftWork_d;
          shiftCnt_q <= shiftCnt_q - SHW'(1);
          if (shiftCnt_q == SHW'(1)) begin
            result_q   <= shiftWork_d;
            carry_q    <= 1'b0;
            overflow_q <= 1'b0;
            zero_q     <= (shiftWork_d == '0);
            negative_q <= shiftWork_d[WIDTH-1];
            outValid_q <= 1'b1;
            state_q    <= HOLD;
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            outValid_q <= 1'b0;
            inReady_q  <= 1'b1;
            state_q    <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Outputs come straight from registers.
  assign bus.in_ready  = inReady_q;
  assign bus.out_valid = outValid_q;
  assign bus.result    = result_q;
  assign bus.carryout  = carry_q;
  assign bus.zero      = zero_q;
  assign bus.negative  = negative_q;
  assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: self-checking bench for seq_alu at WIDTH=64.
// A table of hand-computed vectors is pushed through a scoreboard queue,
// followed by hand-written backpressure and reset-abort sequences.
module tb_seq_alu;

  localparam int WIDTH = 64;
  localparam int NUM_VECS = 17;

  logic clk = 1'b0;
  logic reset = 1'b0;

  seq_alu_if #(.WIDTH(WIDTH)) bus ();

  seq_alu #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] result;
    logic [3:0]  flags;
    int          lat;
  } vec_t;

  vec_t vecs[NUM_VECS];
  vec_t sbQueue[$];
  int   testsRun = 0;
  int   testsFailed = 0;

  // One comparison: counts it and reports a FAIL line on mismatch.
  task automatic check(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Fills one table entry; flags are {carryout, zero, negative, overflow}.
  task automatic setVec(input int idx, input logic [2:0] op,
                        input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] res, input logic [3:0] flags,
                        input int lat);
    vecs[idx].op     = op;
    vecs[idx].a      = a;
    vecs[idx].b      = b;
    vecs[idx].result = res;
    vecs[idx].flags  = flags;
    vecs[idx].lat    = lat;
  endtask

  // Waits (bounded) for in_ready, drives one request for the accept edge
  // and pushes its expected outcome into the scoreboard.
  task automatic applyStimulus(input vec_t v);
    int waitCycles = 0;
    @(negedge clk);
    while (!bus.in_ready && waitCycles < 20) begin
      @(negedge clk);
      waitCycles++;
    end
    check("accept_in_ready", 128'(bus.in_ready), 128'(1));
    if (!bus.in_ready) return;
    bus.in_valid = 1'b1;
    bus.op = v.op;
    bus.a = v.a;
    bus.b = v.b;
    sbQueue.push_back(v);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  // Waits (bounded) for out_valid counting edges since accept, compares
  // against the scoreboard head, optionally stalls the consumer for
  // holdCycles while firing junk requests, then takes the result.
  task automatic checkOutput(input string name, input int holdCycles);
    int   edges = 0;
    vec_t e;
    logic [69:0] held;
    while (!bus.out_valid && edges < 100) begin
      @(posedge clk);
      #1;
      edges++;
    end
    check({name, "_out_valid"}, 128'(bus.out_valid), 128'(1));
    if (!bus.out_valid || sbQueue.size() == 0) return;
    e = sbQueue.pop_front();
    check({name, "_latency"}, 128'(edges), 128'(e.lat));
    check({name, "_result"}, 128'(bus.result), 128'(e.result));
    check({name, "_flags"},
          128'({bus.carryout, bus.zero, bus.negative, bus.overflow}),
          128'(e.flags));
    held = {1'b1, 1'b0, e.flags, e.result};
    for (int i = 0; i < holdCycles; i++) begin
      @(negedge clk);
      bus.in_valid = i[0];
      bus.op = 3'b010;
      bus.a = {$urandom, $urandom};
      bus.b = {$urandom, $urandom};
      @(posedge clk);
      #1;
      check({name, "_hold_stable"},
            128'({bus.out_valid, bus.in_ready, bus.carryout, bus.zero,
                  bus.negative, bus.overflow, bus.result}),
            128'(held));
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check({name, "_release"}, 128'({bus.out_valid, bus.in_ready}),
          128'(2'b01));
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  initial begin : mainSeq
    vec_t v;
    logic sawValid;

    setVec(0,  3'b000, 64'hFF00_FF00_1234_5678, 64'h0F0F_0F0F_FFFF_0000,
           64'h0F00_0F00_1234_0000, 4'b0000, 1);
    setVec(1,  3'b001, 64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555,
           64'hFFFF_FFFF_FFFF_FFFF, 4'b0010, 1);
    setVec(2,  3'b001, 64'h1234, 64'h1234, 64'h0, 4'b0100, 1);
    setVec(3,  3'b010, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1,
           64'h8000_0000_0000_0000, 4'b0011, 1);
    setVec(4,  3'b010, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h0, 4'b1100, 1);
    setVec(5,  3'b011, 64'h5, 64'h5, 64'h0, 4'b1100, 1);
    setVec(6,  3'b011, 64'h0, 64'h1, 64'hFFFF_FFFF_FFFF_FFFF, 4'b0010, 1);
    setVec(7,  3'b011, 64'h8000_0000_0000_0000, 64'h1,
           64'h7FFF_FFFF_FFFF_FFFF, 4'b1001, 1);
    setVec(8,  3'b100, 64'hF0, 64'h0F, 64'hFF, 4'b0000, 1);
    setVec(9,  3'b101, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h1, 4'b0000, 1);
    setVec(10, 3'b101, 64'h1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 4'b0100, 1);
    setVec(11, 3'b101, 64'h8000_0000_0000_0000, 64'h1, 64'h1, 4'b0000, 1);
    setVec(12, 3'b110, 64'h1, 64'd63, 64'h8000_0000_0000_0000, 4'b0010, 63);
    setVec(13, 3'b111, 64'h8000_0000_0000_0000, 64'd4,
           64'h0800_0000_0000_0000, 4'b0000, 4);
    setVec(14, 3'b110, 64'h1234, 64'd64, 64'h1234, 4'b0000, 1);
    setVec(15, 3'b111, 64'hF0, 64'hFFFF_FFFF_FFFF_FF01, 64'h78, 4'b0000, 1);
    setVec(16, 3'b110, 64'h8000_0000_0000_0001, 64'd1, 64'h2, 4'b0000, 1);

    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.op = 3'b000;
    bus.a = '0;
    bus.b = '0;

    // Reset: outputs must be zero without any clock edge.
    #2;
    reset = 1'b1;
    #1;
    check("reset_outputs",
          128'({bus.in_ready, bus.out_valid, bus.carryout, bus.zero,
                bus.negative, bus.overflow, bus.result}), 128'(0));
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("in_ready_after_reset", 128'(bus.in_ready), 128'(1));

    // Table-driven vectors; the overflowing ADD also gets 10 stall cycles.
    for (int i = 0; i < NUM_VECS; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d", i), (i == 3) ? 10 : 0);
    end

    // Reset 5 edges into a 40-bit shift: the shift must never complete.
    v.op = 3'b110;
    v.a = 64'h1;
    v.b = 64'd40;
    v.result = 64'h100_0000_0000;
    v.flags = 4'b0000;
    v.lat = 40;
    applyStimulus(v);
    repeat (5) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("abort_reset_outputs",
          128'({bus.in_ready, bus.out_valid, bus.carryout, bus.zero,
                bus.negative, bus.overflow, bus.result}), 128'(0));
    sbQueue.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("abort_in_ready", 128'(bus.in_ready), 128'(1));
    sawValid = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) sawValid = 1'b1;
    end
    check("abort_no_result", 128'(sawValid), 128'(0));

    v.op = 3'b010;
    v.a = 64'd2;
    v.b = 64'd3;
    v.result = 64'd5;
    v.flags = 4'b0000;
    v.lat = 1;
    applyStimulus(v);
    checkOutput("post_abort_add", 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  // Global watchdog so the bench can never hang.
  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter WIDTH, default 64, operand/result width; SHALL be a power of two, minimum 8.
REQ-002 Derived constant SHW = log2(WIDTH), the shift-amount width; it is not a user parameter.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  reset is asynchronous and active-high.
REQ-005 in_valid  input  1  request valid.
REQ-006 in_ready  output  1  block can accept a request.
REQ-007 op  input  3  operation select (REQ-012).
REQ-008 a, b  input  WIDTH each  operands, two's complement.
REQ-009 out_valid  output  1  result valid.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 result (WIDTH), carryout, zero, negative, overflow  output  result and flags (1 bit each flag).

Function
REQ-012 op encoding SHALL be:
- 000 AND
- 001 XOR
- 010 ADD
- 011 SUB (a-b)
- 100 OR
- 101 SLT (signed a<b, result 1 or 0)
- 110 SLL (a << shamt)
- 111 SRL (a >> shamt, logical)
REQ-013 shamt SHALL be b[SHW-1:0]; upper bits of b are ignored.
REQ-014 FSM states SHALL be IDLE, EXEC, SHIFT and HOLD; in_ready = 1 only in IDLE.
REQ-015 A request SHALL be accepted on a rising edge with in_valid=1 and in_ready=1; op, a and b are captured on that edge. Inputs are ignored at all other times.
REQ-016 Non-shift ops, and shifts with shamt=0, SHALL follow IDLE->EXEC on the accept edge, then EXEC->HOLD on the next edge with result and flags registered. Latency is 1 edge.
REQ-017 Shifts with shamt=k>0 SHALL follow IDLE->SHIFT on the accept edge, loading work=a and cnt=k.
- Each SHIFT edge shifts work by one bit (zero fill) and decrements cnt.
- The edge on which cnt goes 1->0 enters HOLD with result=work.
- Latency is exactly k edges.
REQ-018 In HOLD, out_valid SHALL be 1 and result and flags SHALL be stable; an edge with out_ready=1 returns to IDLE and clears out_valid.
REQ-019 out_ready SHALL be ignored outside HOLD; there is no accept and complete on the same edge, so a new request needs in_ready=1 in a later cycle.
REQ-020 ADD/SUB SHALL be computed as a + b and a + ~b + 1 respectively, at WIDTH bits, modulo 2^WIDTH.
REQ-021 carryout SHALL be the carry out of the MSB for ADD/SUB (for SUB, 1 = no borrow) and 0 for all other ops.
REQ-022 overflow SHALL be signed overflow for ADD/SUB and 0 otherwise.
REQ-023 SLT SHALL use the SUB path, giving result = negative XOR overflow of a-b, zero-extended to WIDTH.
REQ-024 zero SHALL be (result == 0) and negative SHALL be result[WIDTH-1], for every op.
REQ-025 Outputs SHALL hold their last values in IDLE, EXEC and SHIFT; only out_valid qualifies them.

Reset
REQ-026 While reset=1, the state SHALL be IDLE and in_ready, out_valid, result, carryout, zero, negative and overflow SHALL all be 0; this takes effect immediately, without waiting for a clock edge.
REQ-027 Reset asserted in EXEC, SHIFT or HOLD SHALL abort the operation; no result is ever presented for it.
REQ-028 in_ready SHALL rise in the first cycle after reset deasserts.

Verification (WIDTH=64)
REQ-029 ADD a=0x7FFF_FFFF_FFFF_FFFF, b=1 -> result 0x8000_0000_0000_0000, overflow=1, carryout=0, negative=1, zero=0; out_valid 1 edge after accept.
REQ-030 SUB 5-5 -> result 0, zero=1, carryout=1. SUB 0-1 -> 0xFFFF_FFFF_FFFF_FFFF, carryout=0, negative=1, overflow=0.
REQ-031 Shift latency:
- SLL a=1, b=63 -> 0x8000_0000_0000_0000, out_valid exactly 63 edges after accept.
- SRL a=0x8000_0000_0000_0000, b=4 -> 0x0800_0000_0000_0000 after 4 edges.
- SLL b=64 (shamt=0) -> result=a after 1 edge.
REQ-032 Backpressure: out_ready=0 for 10 cycles in HOLD -> result/flags unchanged, in_ready=0, in_valid pulses ignored; out_ready=1 -> IDLE next edge.
REQ-033 Reset in SHIFT 5 edges into a 40-bit shift -> out_valid stays 0, all outputs 0 during reset, in_ready=1 after release; the next ADD 2+3 -> 5.
REQ-034 SLT a=-1, b=1 -> result 1; SLT a=1, b=-1 -> result 0; SLT a=0x8000_0000_0000_0000, b=1 -> result 1 (overflow case).
